// File: rtl/mem_interface.sv
// mem_interface: datapath-side memory responder for the microprogrammed CU.
//
// Holds MAR/MBR and runs one read or write transaction per start strobe
// against a variable-latency RAM port, pulsing mfc when the transaction ends.
//
// Optional feature: define MEMIF_TIMEOUT_EN to bound the WAIT state to TMO
// cycles; on expiry the transaction completes with mfc, MBR untouched and a
// sticky err flag. Without the macro WAIT is unbounded and err is tied 0.
//
// Ports:
//   CLK, reset           clock (rising edge), async active-high reset
//   bus_in               internal bus value (MAR/MBR load source)
//   mar_in, mbr_in       load MAR / MBR from bus_in (ignored while busy)
//   mbr_out              drive MBR onto bus_out (bus_out_en mirrors it)
//   start, rnw           start a transaction; rnw=1 read, 0 write
//   bus_out, bus_out_en  MBR onto the bus when mbr_out=1, else 0
//   mfc, busy, err       completion pulse, in-progress, sticky timeout
//   ram_addr, ram_wdata  always MAR / MBR
//   ram_re, ram_we       one-cycle request pulses
//   ram_rdata, ram_ready RAM read data / acknowledge
//   state_dbg            current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
//
// Handshake: the CU pulses start for one cycle while idle and waits for the
// one-cycle mfc pulse before issuing another start. Towards the RAM, ram_re or
// ram_we is a one-cycle request; the RAM acknowledges with ram_ready (any
// number of cycles later, sampled only in WAIT), with ram_rdata valid in that
// same cycle for reads.
module mem_interface #(
   parameter int AW  = 8,
   parameter int DW  = 8,
   parameter int TMO = 15
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic [DW-1:0] bus_in,
   input  logic          mar_in,
   input  logic          mbr_in,
   input  logic          mbr_out,
   input  logic          start,
   input  logic          rnw,
   output logic [DW-1:0] bus_out,
   output logic          bus_out_en,
   output logic          mfc,
   output logic          busy,
   output logic          err,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_re,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata,
   input  logic          ram_ready,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          op_q, op_d;       // 1 = read, captured from rnw with start
   logic [AW-1:0] mar_q, mar_d;
   logic [DW-1:0] mbr_q, mbr_d;

`ifdef MEMIF_TIMEOUT_EN
   localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);
   logic [CW-1:0] cnt_q, cnt_d;     // WAIT cycles already spent without ready
   logic          err_q, err_d;
`else
   // TMO only has meaning with the timeout feature compiled in.
   logic          unused_tmo;
   assign unused_tmo = ^TMO;
`endif

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= 1'b0;
         mar_q   <= '0;
         mbr_q   <= '0;
`ifdef MEMIF_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mar_q   <= mar_d;
         mbr_q   <= mbr_d;
`ifdef MEMIF_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mar_d   = mar_q;
      mbr_d   = mbr_q;
`ifdef MEMIF_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif

      // Register loads are open whenever no request is outstanding. A load
      // in the same cycle as start lands before REQ, so the request uses it.
      if (!busy) begin
         if (mar_in) mar_d = bus_in[AW-1:0];
         if (mbr_in) mbr_d = bus_in;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = REQ;
               op_d    = rnw;
            end
         end
         REQ: begin
            state_d = WAIT;
`ifdef MEMIF_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            if (ram_ready) begin
               state_d = DONE;
               if (op_q) mbr_d = ram_rdata;
            end
`ifdef MEMIF_TIMEOUT_EN
            // Ready on the last allowed cycle still wins over the timeout.
            else if (cnt_q == CW'(TMO - 1)) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy       = (state_q == REQ) || (state_q == WAIT);
   assign mfc        = (state_q == DONE);
   assign ram_re     = (state_q == REQ) && op_q;
   assign ram_we     = (state_q == REQ) && !op_q;
   assign ram_addr   = mar_q;
   assign ram_wdata  = mbr_q;
   assign bus_out    = mbr_out ? mbr_q : '0;
   assign bus_out_en = mbr_out;
   assign state_dbg  = state_q;

`ifdef MEMIF_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_interface.sv
module tb_mem_interface;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] bus_in;
   logic       mar_in, mbr_in, mbr_out, start, rnw;
   logic [7:0] bus_out;
   logic       bus_out_en, mfc, busy, err;
   logic [7:0] ram_addr, ram_wdata;
   logic       ram_re, ram_we;
   logic [7:0] ram_rdata;
   logic       ram_ready;
   logic [1:0] state_dbg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Expected RAM requests: {re, we, addr, wdata}
   logic [17:0] req_q[$];
   // Expected completions: {cycle[15:0], err, addr, mbr}
   logic [32:0] exp_q[$];

   mem_interface #(.AW(8), .DW(8), .TMO(15)) dut (
      .CLK(clk), .reset(reset), .bus_in(bus_in), .mar_in(mar_in),
      .mbr_in(mbr_in), .mbr_out(mbr_out), .start(start), .rnw(rnw),
      .bus_out(bus_out), .bus_out_en(bus_out_en), .mfc(mfc), .busy(busy),
      .err(err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .ram_ready(ram_ready), .state_dbg(state_dbg)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitors / scoreboard ----------------
   always @(negedge clk) begin
      if (!reset) begin
         if (ram_re || ram_we) begin
            if (req_q.size() == 0) begin
               chk("req_unexpected", {22'd0, ram_re, ram_we, ram_addr, ram_wdata}, 40'd0);
            end else begin
               chk("ram_request", {22'd0, ram_re, ram_we, ram_addr, ram_wdata},
                   {22'd0, req_q.pop_front()});
            end
         end
         if (mfc) begin
            if (exp_q.size() == 0) begin
               chk("mfc_unexpected", {23'd0, cyc[15:0], err, ram_addr, bus_out}, 40'd0);
            end else begin
               chk("mfc_result", {7'd0, cyc[15:0], err, ram_addr, bus_out},
                   {7'd0, exp_q.pop_front()});
               chk("busy_in_done", {39'd0, busy}, 40'd0);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_mar(input logic [7:0] v);
      bus_in = v; mar_in = 1'b1; tick(); mar_in = 1'b0;
   endtask

   task automatic load_mbr(input logic [7:0] v);
      bus_in = v; mbr_in = 1'b1; tick(); mbr_in = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ram_re"},    {39'd0, ram_re},    40'd0);
      chk({tag, "_ram_we"},    {39'd0, ram_we},    40'd0);
      chk({tag, "_mfc"},       {39'd0, mfc},       40'd0);
      chk({tag, "_busy"},      {39'd0, busy},      40'd0);
      chk({tag, "_err"},       {39'd0, err},       40'd0);
      chk({tag, "_ram_addr"},  {32'd0, ram_addr},  40'd0);
      chk({tag, "_ram_wdata"}, {32'd0, ram_wdata}, 40'd0);
      chk({tag, "_bus_out"},   {32'd0, bus_out},   40'd0);
      chk({tag, "_state"},     {38'd0, state_dbg}, 40'd0);
   endtask

   // One full transaction. ram_ready is raised in WAIT cycle waits+1, so mfc
   // lands at start + 3 + waits. Expectations are pushed at start time.
   task automatic txn(input logic rd, input logic [7:0] rdata, input int waits,
                      input logic ready_in_req, input logic disturb,
                      input logic [7:0] e_addr, input logic [7:0] e_wdata,
                      input logic [7:0] e_mbr, input logic e_err);
      int s;
      s = cyc;
      req_q.push_back({rd, ~rd, e_addr, e_wdata});
      exp_q.push_back({16'(s + 3 + waits), e_err, e_addr, e_mbr});
      start = 1'b1; rnw = rd;
      tick();                                   // REQ
      start = 1'b0; mar_in = 1'b0; mbr_in = 1'b0;
      ram_ready = ready_in_req; ram_rdata = rdata;
      tick();                                   // first WAIT cycle
      for (int i = 0; i < waits; i++) begin
         ram_ready = 1'b0;
         if (disturb && i == 0) begin
            start = 1'b1; mar_in = 1'b1; bus_in = 8'hFF;
         end
         #1;
         chk("busy_in_wait", {39'd0, busy}, 40'd1);
         tick();
         start = 1'b0; mar_in = 1'b0;
      end
      ram_ready = 1'b1; ram_rdata = rdata;
      tick();                                   // DONE
      ram_ready = 1'b0; ram_rdata = 8'h00;
      tick();                                   // back in IDLE
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; bus_in = 8'h00; mar_in = 1'b0; mbr_in = 1'b0;
      mbr_out = 1'b1; start = 1'b0; rnw = 1'b0;
      ram_rdata = 8'h00; ram_ready = 1'b0;
      #2;
      check_all_zero("reset");
      tick(); tick();
      reset = 1'b0;
      tick();

      // Read, zero-wait: MAR=0x3C, rdata 0xA5, mfc at start+3.
      load_mar(8'h3C);
      txn(1'b1, 8'hA5, 0, 1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0);
      chk("bus_out_after_read", {32'd0, bus_out}, {32'd0, 8'hA5});

      // Write, ready ignored in REQ, 4 cycles of latency, disturbance in WAIT.
      load_mar(8'h10);
      load_mbr(8'h7E);
      txn(1'b0, 8'h99, 3, 1'b1, 1'b1, 8'h10, 8'h7E, 8'h7E, 1'b0);
      chk("mar_after_ignored_load", {32'd0, ram_addr}, {32'd0, 8'h10});
      chk("idle_after_write", {38'd0, state_dbg}, 40'd0);

      // Reset in the middle of WAIT: request seen, no mfc, everything clears.
      req_q.push_back({1'b1, 1'b0, 8'h10, 8'h7E});
      start = 1'b1; rnw = 1'b1;
      tick();                                   // REQ
      start = 1'b0;
      tick();                                   // WAIT
      #2 reset = 1'b1;
      #1;
      check_all_zero("midreset");
      tick();
      reset = 1'b0;
      tick();

      // Same-cycle MAR load and start; MBR was cleared by the reset.
      bus_in = 8'h22; mar_in = 1'b1;
      txn(1'b1, 8'h5A, 1, 1'b0, 1'b0, 8'h22, 8'h00, 8'h5A, 1'b0);

`ifdef MEMIF_TIMEOUT_EN
      // Timeout: WAIT entered at s+2, 15 cycles without ready, mfc at s+17.
      begin
         int s;
         s = cyc;
         req_q.push_back({1'b1, 1'b0, 8'h22, 8'h5A});
         exp_q.push_back({16'(s + 17), 1'b1, 8'h22, 8'h5A});
         start = 1'b1; rnw = 1'b1;
         tick();
         start = 1'b0;
         repeat (20) tick();
      end
      txn(1'b1, 8'hC3, 0, 1'b0, 1'b0, 8'h22, 8'h5A, 8'hC3, 1'b1);
`endif

      // bus_out gating is independent of state.
      mbr_out = 1'b0;
      #1;
      chk("bus_out_gated", {32'd0, bus_out}, 40'd0);
      chk("bus_out_en_low", {39'd0, bus_out_en}, 40'd0);
      mbr_out = 1'b1;
      #1;
      chk("bus_out_en_high", {39'd0, bus_out_en}, 40'd1);

      repeat (3) tick();
      chk("pending_requests", 40'(req_q.size()), 40'd0);
      chk("pending_completions", 40'(exp_q.size()), 40'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- Datapath-side responder to the microprogrammed control unit's memory control signals (MAR_in, MBR_out, rnw, WMFC).
- Holds the MAR and MBR registers and runs one read or write transaction per request against a variable-latency RAM port.
- Raises mfc (memory function complete) so a control word with WMFC set can release its stall.
- Sits between the 8-bit internal bus and the program/data RAM.

Parameters:
- AW, 8, address width (MAR width)
- DW, 8, data width (MBR width, bus width)
- TMO, 15, ram_ready timeout in cycles; used only with MEMIF_TIMEOUT_EN

Ports:
- CLK  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- bus_in  input  DW  internal bus value
- mar_in  input  1  load MAR from bus_in[AW-1:0]
- mbr_in  input  1  load MBR from bus_in (write data)
- mbr_out  input  1  drive MBR onto bus_out
- start  input  1  begin a memory transaction (one-cycle strobe)
- rnw  input  1  1 = read, 0 = write; sampled with start
- bus_out  output  DW  MBR value while mbr_out=1, else 0
- bus_out_en  output  1  equals mbr_out
- mfc  output  1  one-cycle completion pulse
- busy  output  1  transaction in progress
- err  output  1  sticky timeout flag (MEMIF_TIMEOUT_EN only; else tied 0)
- ram_addr  output  AW  RAM address
- ram_wdata  output  DW  RAM write data
- ram_re  output  1  RAM read request
- ram_we  output  1  RAM write request
- ram_rdata  input  DW  RAM read data, valid when ram_ready=1
- ram_ready  input  1  RAM acknowledge

Behaviour:
- Reset, asynchronous: state=IDLE; MAR=0, MBR=0, mfc=0, busy=0, err=0, ram_re=0, ram_we=0; ram_addr and ram_wdata read 0.
- Register loads:
  - mar_in loads MAR at the rising edge.
  - mbr_in loads MBR at the rising edge.
  - Both loads are ignored while busy=1.
  - Loads are allowed in the same cycle as start. The transaction uses the newly loaded values, i.e. start is acted on one cycle later, in REQ.
- ram_addr=MAR and ram_wdata=MBR at all times (combinational from the registers).
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - start=1 -> REQ; latch rnw into an internal op bit; busy=1 from the next cycle.
  - start=0 -> remain in IDLE.
- REQ:
  - Assert ram_re (op=1) or ram_we (op=0) for exactly one cycle.
  - Next state is WAIT.
- WAIT:
  - Hold ram_re/ram_we deasserted.
  - ram_ready=1 -> DONE; on a read, MBR<=ram_rdata in the same edge.
  - ram_ready=0 -> remain in WAIT (unbounded without the macro).
- DONE:
  - mfc=1 for this single cycle; busy=0.
  - Next state is IDLE.
- Minimum latency: start in cycle 0, REQ in cycle 1. With ram_ready=1 in cycle 2, mfc=1 in cycle 3.
- ram_ready seen in REQ is ignored; it is only sampled in WAIT.
- start while busy, or in DONE, is ignored (no queueing). The CU must not issue a new start before mfc.
- mbr_out is combinational and independent of state. In DONE, bus_out already shows the read data.
- Reset mid-transaction aborts immediately: no mfc, no further ram_re/ram_we, MBR cleared.

Optional Feature:
- Macro: MEMIF_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - After TMO consecutive cycles without ram_ready -> DONE, with mfc pulsed, MBR unchanged, and err set sticky.
  - err clears only on reset.
  - ram_ready on the TMO-th cycle counts as success (err not set).
- Undefined: no counter; WAIT is unbounded; err is tied to 0.

Test Plan:
- Read, zero-wait: MAR<=0x3C via bus_in/mar_in; start, rnw=1; ram_rdata=0xA5 with ram_ready in the first WAIT cycle -> ram_re pulse with ram_addr=0x3C, mfc at start+3; mbr_out gives bus_out=0xA5.
- Write with 4-cycle ram latency: MAR=0x10, MBR=0x7E, start, rnw=0 -> single ram_we pulse, ram_addr=0x10, ram_wdata=0x7E, mfc at start+6, MBR still 0x7E.
- Ignored inputs while busy: during WAIT, drive start=1 and mar_in with bus_in=0xFF -> no second request, MAR stays 0x10, exactly one mfc.
- Reset mid-WAIT: assert reset during WAIT -> all outputs 0 asynchronously, no mfc, next start behaves normally.
- Same-cycle load + start: mar_in with bus_in=0x22 together with start (read) -> ram_addr=0x22 while ram_re is high.
- MEMIF_TIMEOUT_EN, TMO=15: ram_ready held 0 -> mfc 15 cycles after entering WAIT, err=1, MBR unchanged; a following normal read completes with err still 1.
